// File: rtl/keypad_input_port.sv
// keypad_input_port: Avalon-MM slave that synchronises, debounces and edge-captures button inputs.
// Define KEYPAD_DEBOUNCE_EN to build the tick prescaler and the per-bit debounce counters.
module keypad_input_port #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE       = 1000,
  parameter int DEBOUNCE_TICKS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_RISE_EN = 3'd1;
  localparam logic [2:0] A_MASK    = 3'd2;
  localparam logic [2:0] A_CAPTURE = 3'd3;
  localparam logic [2:0] A_FALL_EN = 3'd4;
  localparam logic [2:0] A_RAW     = 3'd5;

  generate
    if (WIDTH < 1 || WIDTH > 32 || PRESCALE < 1 || DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255)
    begin : g_bad_cfg
      $error("keypad_input_port: parameter out of range");
    end
  endgenerate

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_next;
  logic             w_unused_wdata;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = ^writedata;
  assign w_edge         = (r_stable & ~r_prev & r_rise_en) | (~r_stable & r_prev & r_fall_en);
  assign w_clr          = (w_wr && address == A_CAPTURE) ? w_wdata : '0;
  assign irq            = |(r_edge_cap & r_irq_mask);
  assign readdata       = r_readdata;

  // Two-flop synchroniser on the raw pins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= in_port;
      r_sync <= r_meta;
    end
  end

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic       w_tick;
  logic [7:0] r_cnt [WIDTH];

  generate
    if (PRESCALE == 1) begin : g_tick_always
      assign w_tick = 1'b1;
    end else begin : g_prescaler
      logic [PCW-1:0] r_pcnt;
      always_ff @(posedge clk) begin
        if (reset)                                r_pcnt <= '0;
        else if (r_pcnt == PCW'(PRESCALE - 1))    r_pcnt <= '0;
        else                                      r_pcnt <= r_pcnt + PCW'(1);
      end
      assign w_tick = (r_pcnt == PCW'(PRESCALE - 1));
    end
  endgenerate

  // Debounce: a bit must disagree with its stable value for DEBOUNCE_TICKS ticks in a row
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_cnt[i] == 8'(DEBOUNCE_TICKS - 1)) begin
            r_stable[i] <= r_sync[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) r_stable <= '0;
    else       r_stable <= r_sync;
  end
`endif

  // Edge detection, capture and software registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev     <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
    end else begin
      r_prev     <= r_stable;
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
      if (w_wr) begin
        case (address)
          A_RISE_EN: r_rise_en  <= w_wdata;
          A_MASK:    r_irq_mask <= w_wdata;
          A_FALL_EN: r_fall_en  <= w_wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_next = '0;
    case (address)
      A_DATA:    w_rd_next = zext(r_stable);
      A_RISE_EN: w_rd_next = zext(r_rise_en);
      A_MASK:    w_rd_next = zext(r_irq_mask);
      A_CAPTURE: w_rd_next = zext(r_edge_cap);
      A_FALL_EN: w_rd_next = zext(r_fall_en);
      A_RAW:     w_rd_next = zext(r_sync);
      default:   w_rd_next = '0;
    endcase
  end

  // Read data is registered every cycle, independent of chipselect
  always_ff @(posedge clk) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= w_rd_next;
  end
endmodule

// File: tb/tb_keypad_input_port.sv
// Randomised bench for keypad_input_port against a tick-counting behavioural model.
module tb_keypad_input_port;
  localparam int W = 8;
  localparam int P = 4;
  localparam int D = 3;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic        clk;
  logic        r_reset;
  logic [2:0]  r_addr;
  logic        r_cs;
  logic        r_wn;
  logic [31:0] r_wd;
  logic [W-1:0] r_pin;
  logic [31:0] readdata;
  logic        irq;

  keypad_input_port #(.WIDTH(W), .PRESCALE(P), .DEBOUNCE_TICKS(D)) dut (
    .clk(clk), .reset(r_reset), .address(r_addr), .chipselect(r_cs), .write_n(r_wn),
    .writedata(r_wd), .in_port(r_pin), .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural reference state
  logic [W-1:0] m_meta = '0, m_sync = '0, m_stable = '0, m_last = '0;
  logic [W-1:0] m_rise = '0, m_fall = '0, m_mask = '0, m_cap = '0;
  logic [31:0]  m_rd = '0;
  int           m_n = 0;
  int           m_run [W];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference: stable flips once D ticks have elapsed
  // since the synchronised input started disagreeing with it.
  task automatic model_step();
    logic [W-1:0] st_new, edges, clr;
    logic [31:0]  rd;
    if (r_reset) begin
      m_meta = '0; m_sync = '0; m_stable = '0; m_last = '0;
      m_rise = '0; m_fall = '0; m_mask = '0; m_cap = '0;
      m_rd = '0; m_n = 0;
      for (int i = 0; i < W; i++) m_run[i] = -1;
      return;
    end
    st_new = m_stable;
    for (int i = 0; i < W; i++) begin
      if (!DEB) begin
        st_new[i] = m_sync[i];
      end else if (m_sync[i] == m_stable[i]) begin
        m_run[i] = -1;
      end else begin
        if (m_run[i] < 0) m_run[i] = m_n;
        if (((m_n + 1) / P) - (m_run[i] / P) == D) begin
          st_new[i] = m_sync[i];
          m_run[i]  = -1;
        end
      end
    end
    edges = (m_stable & ~m_last & m_rise) | (~m_stable & m_last & m_fall);
    clr   = (r_cs && !r_wn && r_addr == 3'd3) ? r_wd[W-1:0] : '0;
    case (r_addr)
      3'd0:    rd = {24'd0, m_stable};
      3'd1:    rd = {24'd0, m_rise};
      3'd2:    rd = {24'd0, m_mask};
      3'd3:    rd = {24'd0, m_cap};
      3'd4:    rd = {24'd0, m_fall};
      3'd5:    rd = {24'd0, m_sync};
      default: rd = 32'd0;
    endcase
    m_cap = (m_cap & ~clr) | edges;
    if (r_cs && !r_wn) begin
      if (r_addr == 3'd1) m_rise = r_wd[W-1:0];
      if (r_addr == 3'd2) m_mask = r_wd[W-1:0];
      if (r_addr == 3'd4) m_fall = r_wd[W-1:0];
    end
    m_last   = m_stable;
    m_stable = st_new;
    m_sync   = m_meta;
    m_meta   = r_pin;
    m_rd     = rd;
    m_n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    chk("readdata", readdata, m_rd);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    r_addr = a; r_wd = d; r_cs = 1'b1; r_wn = 1'b0;
    step();
    r_cs = 1'b0; r_wn = 1'b1;
  endtask

  task automatic do_reset(input int k);
    r_reset = 1'b1;
    run(k);
    r_reset = 1'b0;
  endtask

  initial begin
    int guard;
    r_reset = 1'b1; r_addr = '0; r_cs = 1'b0; r_wn = 1'b1; r_wd = '0; r_pin = '0;
    for (int i = 0; i < W; i++) m_run[i] = -1;

    // Reset state: every address reads zero
    do_reset(3);
    for (int a = 0; a < 8; a++) begin
      r_addr = 3'(a);
      step();
      chk("reset_read", readdata, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);
    end

    // Rising edge on bit 0 raises irq, write-1 clears it
    wr(3'd1, 32'h01);
    wr(3'd2, 32'h01);
    r_pin[0] = 1'b1;
    r_addr = 3'd0;
    guard = 0;
    while (readdata !== 32'h01 && guard < 16) begin step(); guard++; end
    chk("data_rise_in_time", {31'd0, guard < 16}, 32'd1);
    r_addr = 3'd3;
    step();
    chk("cap_bit0", readdata, 32'h01);
    chk("irq_bit0", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'hFFFF_FF01);
    step();
    chk("cap_cleared", readdata, 32'h00);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // Short pulse on bit 3: visible on RAW, filtered from DATA when debounced
    r_addr = 3'd5;
    r_pin[3] = 1'b1;
    run(6);
    r_pin[3] = 1'b0;
    run(3);
    r_addr = 3'd0;
    run(20);
`ifdef KEYPAD_DEBOUNCE_EN
    chk("glitch_data", readdata, 32'h01);
`endif
    r_addr = 3'd3;
    step();
    chk("glitch_cap", readdata, 32'h00);

    // Falling-only capture on bit 7, masked off
    wr(3'd2, 32'h00);
    wr(3'd4, 32'h80);
    r_pin[7] = 1'b1;
    r_addr = 3'd3;
    run(20);
    chk("fall_only_no_rise", readdata, 32'h00);
    r_pin[7] = 1'b0;
    run(20);
    chk("fall_cap", readdata, 32'h80);
    chk("fall_irq_masked", {31'd0, irq}, 32'd0);
    wr(3'd3, 32'h80);

    // Clear and new edge on bit 1 in the same cycle: edge wins
    wr(3'd1, 32'h02);
    wr(3'd4, 32'h02);
    r_pin[1] = 1'b1;
    r_addr = 3'd3;
    run(20);
    chk("both_rise_cap", readdata, 32'h02);
    r_pin[1] = 1'b0;
    guard = 0;
    while (!(m_stable[1] == 1'b0 && m_last[1] == 1'b1) && guard < 40) begin step(); guard++; end
    chk("fall_detect_in_time", {31'd0, guard < 40}, 32'd1);
    wr(3'd3, 32'h02);
    step();
    chk("edge_wins_clear", readdata, 32'h02);
    wr(3'd3, 32'h02);
    step();
    chk("clear_after", readdata, 32'h00);

    // Single-cycle pulse on bit 2
    wr(3'd1, 32'h04);
    wr(3'd2, 32'h04);
    r_pin[2] = 1'b1;
    step();
    r_pin[2] = 1'b0;
    run(2);
    chk("pulse_irq_early", {31'd0, irq}, 32'd0);
    step();
`ifdef KEYPAD_DEBOUNCE_EN
    chk("pulse_filtered", {31'd0, irq}, 32'd0);
`else
    chk("pulse_cap_4cyc", {31'd0, irq}, 32'd1);
`endif
    wr(3'd3, 32'hFF);

    // Reset in the middle of a debounce, input stays high
    r_pin[4] = 1'b1;
    run(5);
    do_reset(2);
    wr(3'd1, 32'h10);
    r_addr = 3'd3;
    run(25);
    chk("held_through_reset", readdata, 32'h10);

    // Randomised traffic checked cycle by cycle against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) r_pin[$urandom_range(0, W-1)] ^= 1'b1;
      r_addr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        r_wd = $urandom;
        r_cs = 1'b1;
        r_wn = 1'b0;
      end else begin
        r_cs = 1'($urandom_range(0, 1));
        r_wn = 1'b1;
      end
      r_reset = ($urandom_range(0, 299) == 0);
      step();
    end
    r_reset = 1'b0; r_cs = 1'b0; r_wn = 1'b1;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
